// File: rtl/piso_pkg.sv
// Shared definitions for the PISO transmitter and its SIPO capture counterpart:
// frame state encoding, default frame geometry and counter sizing.
package piso_pkg;

  localparam int DATA_W_DEF     = 12;
  localparam int START_DLY_DEF  = 1;
  localparam int BIT_CYCLES_DEF = 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SYNC  = 3'd1,
    LEAD  = 3'd2,
    SHIFT = 3'd3,
    DONE  = 3'd4
  } piso_state_e;

  // Bits needed to hold values 0..max_val, never fewer than one.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/piso_tick_counter.sv
// Loadable down-counter that parks at zero; tc_o marks the terminal count.
// Used both for cycle waits (lead-in, per-bit hold) and for counting bits.
module piso_tick_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset_b,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         tc_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // NOTE: every variable assigned in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  // NOTE: state is updated with non-blocking assignments and cleared by the asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == '0);

endmodule

// File: rtl/piso_serial_tx.sv
// Parallel-in/serial-out frame transmitter: frame_sync strobe, lead-in, MSB-first bits, done pulse.
// Build option PISO_PARITY_EN appends an even-parity bit after the LSB.
module piso_serial_tx
  import piso_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int START_DLY  = START_DLY_DEF,
  parameter int BIT_CYCLES = BIT_CYCLES_DEF
) (
  input  logic              clk,
  input  logic              reset_b,
  input  logic [DATA_W-1:0] tx_data_i,
  input  logic              tx_valid_i,
  output logic              tx_ready_o,
  output logic              frame_sync_o,
  output logic              sdata_o,
  output logic              sdata_en_o,
  output logic              tx_done_o,
  output logic              busy_o
);

`ifdef PISO_PARITY_EN
  localparam int NBITS = DATA_W + 1;
`else
  localparam int NBITS = DATA_W;
`endif

  localparam int CYC_MAX = (BIT_CYCLES > START_DLY) ? BIT_CYCLES : START_DLY;
  localparam int CYC_W   = cnt_width(CYC_MAX);
  localparam int BIT_W   = cnt_width(DATA_W);

  localparam logic [CYC_W-1:0] HOLD_LOAD = CYC_W'(BIT_CYCLES - 1);
  localparam logic [CYC_W-1:0] LEAD_LOAD = CYC_W'((START_DLY > 0) ? START_DLY - 1 : 0);
  localparam logic [BIT_W-1:0] BIT_LOAD  = BIT_W'(NBITS - 1);

  // With no lead-in the frame goes straight from the sync cycle to the first bit.
  localparam piso_state_e AFTER_SYNC = (START_DLY > 0) ? LEAD : SHIFT;
  localparam logic [CYC_W-1:0] SYNC_CYC_LOAD = (START_DLY > 0) ? LEAD_LOAD : HOLD_LOAD;

  piso_state_e        state_q;
  logic [NBITS-1:0]   shift_q;
  logic [NBITS-1:0]   load_word;

  logic               cyc_load;
  logic [CYC_W-1:0]   cyc_load_val;
  logic               cyc_dec;
  logic               cyc_tc;
  logic               bit_load;
  logic               bit_dec;
  logic               bit_tc;

`ifdef PISO_PARITY_EN
  assign load_word = {tx_data_i, ^tx_data_i};
`else
  assign load_word = tx_data_i;
`endif

  // Counter control: the cycle counter times the lead-in and each bit hold,
  // the bit counter counts remaining bits of the frame.
  always_comb begin
    cyc_load     = 1'b0;
    cyc_load_val = HOLD_LOAD;
    cyc_dec      = 1'b0;
    bit_load     = 1'b0;
    bit_dec      = 1'b0;
    case (state_q)
      SYNC: begin
        cyc_load     = 1'b1;
        cyc_load_val = SYNC_CYC_LOAD;
        bit_load     = 1'b1;
      end
      LEAD: begin
        if (cyc_tc) begin
          cyc_load = 1'b1;
        end else begin
          cyc_dec = 1'b1;
        end
      end
      SHIFT: begin
        if (cyc_tc) begin
          if (!bit_tc) begin
            cyc_load = 1'b1;
            bit_dec  = 1'b1;
          end
        end else begin
          cyc_dec = 1'b1;
        end
      end
      default: begin
      end
    endcase
  end

  piso_tick_counter #(
    .W (CYC_W)
  ) u_cyc_cnt (
    .clk        (clk),
    .reset_b    (reset_b),
    .load_i     (cyc_load),
    .load_val_i (cyc_load_val),
    .dec_i      (cyc_dec),
    .tc_o       (cyc_tc)
  );

  piso_tick_counter #(
    .W (BIT_W)
  ) u_bit_cnt (
    .clk        (clk),
    .reset_b    (reset_b),
    .load_i     (bit_load),
    .load_val_i (BIT_LOAD),
    .dec_i      (bit_dec),
    .tc_o       (bit_tc)
  );

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state_q <= IDLE;
      shift_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (tx_valid_i) begin
            state_q <= SYNC;
            shift_q <= load_word;
          end
        end
        SYNC: begin
          state_q <= AFTER_SYNC;
        end
        LEAD: begin
          if (cyc_tc) begin
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          if (cyc_tc) begin
            if (bit_tc) begin
              state_q <= DONE;
            end else begin
              shift_q <= {shift_q[NBITS-2:0], 1'b0};
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Outputs decode registered state only; nothing combinational from the inputs.
  assign tx_ready_o   = (state_q == IDLE);
  assign busy_o       = (state_q != IDLE);
  assign frame_sync_o = (state_q == SYNC);
  assign sdata_en_o   = (state_q == SHIFT);
  assign sdata_o      = (state_q == SHIFT) & shift_q[NBITS-1];
  assign tx_done_o    = (state_q == DONE);

endmodule

// File: tb/tb_piso_serial_tx.sv
// Bench for piso_serial_tx: two instances (default geometry and BIT_CYCLES=3/START_DLY=0)
// checked every cycle against a frame-position model, plus literal timing checks.
module tb_piso_serial_tx;

  localparam int DW = 12;
`ifdef PISO_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  typedef struct packed {
    logic rdy;
    logic fs;
    logic sd;
    logic en;
    logic dn;
    logic bz;
  } outs_t;

  localparam outs_t IDLE_OUTS = 6'b100000;

  logic          clk = 1'b0;
  logic          reset_b;
  logic [DW-1:0] tx_data;
  logic          tx_valid;
  logic [1:0]    rdy, fs, sd, en, dn, bz;

  int n_tests = 0;
  int n_fail  = 0;

  // Model state per instance: in-frame flag, cycle index since accept, accepted word.
  bit            m_act [2];
  int            m_k   [2];
  logic [DW-1:0] m_w   [2];

  logic [63:0] r_fs [2];
  logic [63:0] r_sd [2];
  logic [63:0] r_en [2];
  logic [63:0] r_dn [2];
  logic [63:0] r_rd [2];

  always #5 clk = ~clk;

  piso_serial_tx dut_a (
    .clk          (clk),
    .reset_b      (reset_b),
    .tx_data_i    (tx_data),
    .tx_valid_i   (tx_valid),
    .tx_ready_o   (rdy[0]),
    .frame_sync_o (fs[0]),
    .sdata_o      (sd[0]),
    .sdata_en_o   (en[0]),
    .tx_done_o    (dn[0]),
    .busy_o       (bz[0])
  );

  piso_serial_tx #(
    .DATA_W     (DW),
    .START_DLY  (0),
    .BIT_CYCLES (3)
  ) dut_b (
    .clk          (clk),
    .reset_b      (reset_b),
    .tx_data_i    (tx_data),
    .tx_valid_i   (tx_valid),
    .tx_ready_o   (rdy[1]),
    .frame_sync_o (fs[1]),
    .sdata_o      (sd[1]),
    .sdata_en_o   (en[1]),
    .tx_done_o    (dn[1]),
    .busy_o       (bz[1])
  );

  function automatic int sd_of(input int i);
    return (i == 0) ? 1 : 0;
  endfunction

  function automatic int bc_of(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  function automatic int flen(input int i);
    return 3 + sd_of(i) + (DW + PAR) * bc_of(i);
  endfunction

  // Expected outputs from the position k within a frame (k=1 is the cycle after accept).
  function automatic outs_t expect_out(input bit act, input int k, input logic [DW-1:0] w,
                                       input int sdl, input int bc);
    outs_t o;
    int    first;
    int    last;
    int    idx;
    o = IDLE_OUTS;
    if (!act) return o;
    first = 2 + sdl;
    last  = 1 + sdl + (DW + PAR) * bc;
    o.rdy = 1'b0;
    o.bz  = 1'b1;
    if (k == 1) begin
      o.fs = 1'b1;
    end else if (k >= first && k <= last) begin
      idx  = (k - first) / bc;
      o.en = 1'b1;
      o.sd = (idx < DW) ? w[DW-1-idx] : ^w;
    end else if (k == last + 1) begin
      o.dn = 1'b1;
    end
    return o;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!reset_b) begin
        m_act[i] = 1'b0;
        m_k[i]   = 0;
      end else if (!m_act[i]) begin
        if (tx_valid) begin
          m_act[i] = 1'b1;
          m_k[i]   = 1;
          m_w[i]   = tx_data;
        end
      end else begin
        m_k[i]++;
        if (m_k[i] >= flen(i)) m_act[i] = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    outs_t a_o;
    outs_t e_o;
    for (int i = 0; i < 2; i++) begin
      a_o = {rdy[i], fs[i], sd[i], en[i], dn[i], bz[i]};
      if (!reset_b) e_o = IDLE_OUTS;
      else          e_o = expect_out(m_act[i], m_k[i], m_w[i], sd_of(i), bc_of(i));
      check((i == 0) ? "cmp_a" : "cmp_b", 32'(a_o), 32'(e_o));
    end
  end

  function automatic logic [DW-1:0] bits_of(input int i, input int first, input int bc);
    logic [DW-1:0] v;
    for (int j = 0; j < DW; j++) v[DW-1-j] = r_sd[i][first + j * bc];
    return v;
  endfunction

  function automatic int count_en(input int i, input int lo, input int hi);
    int n = 0;
    for (int c = lo; c <= hi; c++) n += int'(r_en[i][c]);
    return n;
  endfunction

  // mode 0: one-cycle valid pulse; 1: valid held, data switched to w2; 2: valid/data toggled mid-frame.
  task automatic sample_frame(input logic [DW-1:0] w, input logic [DW-1:0] w2,
                              input int ncyc, input int mode);
    for (int i = 0; i < 2; i++) begin
      r_fs[i] = '0; r_sd[i] = '0; r_en[i] = '0; r_dn[i] = '0; r_rd[i] = '0;
    end
    @(negedge clk);
    tx_valid = 1'b1;
    tx_data  = w;
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        r_fs[i][c] = fs[i]; r_sd[i][c] = sd[i]; r_en[i][c] = en[i];
        r_dn[i][c] = dn[i]; r_rd[i][c] = rdy[i];
      end
      if (mode == 0 && c == 1) tx_valid = 1'b0;
      if (mode == 1 && c == 1) tx_data = w2;
      if (mode == 2) begin
        if (c >= 4 && c <= 12) begin
          tx_valid = 1'($urandom_range(0, 1));
          tx_data  = DW'($urandom);
        end else begin
          tx_valid = 1'b0;
        end
      end
    end
    tx_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int c = 0; c < 200 && !ok; c++) begin
      @(negedge clk);
      if (rdy == 2'b11) ok = 1'b1;
    end
    check("idle_timeout", 32'(ok), 32'd1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: bench did not reach its end");
    $fatal(1, "bench timeout");
  end

  initial begin
    int la;
    logic dn_seen;
    reset_b  = 1'b0;
    tx_valid = 1'b0;
    tx_data  = '0;
    #1;
    check("reset_outs_a", 32'({rdy[0], fs[0], sd[0], en[0], dn[0], bz[0]}), 32'(6'b100000));
    check("reset_outs_b", 32'({rdy[1], fs[1], sd[1], en[1], dn[1], bz[1]}), 32'(6'b100000));
    repeat (3) @(negedge clk);
    reset_b = 1'b1;
    la = 16 + PAR;

    // Single frame, default geometry.
    wait_idle();
    sample_frame(12'hA5C, 12'h000, 24, 0);
    check("t1_sync_c1", 32'(r_fs[0][1]), 32'd1);
    check("t1_sync_c2", 32'(r_fs[0][2]), 32'd0);
    check("t1_ready_c1", 32'(r_rd[0][1]), 32'd0);
    check("t1_bits", 32'(bits_of(0, 3, 1)), 32'h0000_0A5C);
    check("t1_lead_c2", 32'(r_en[0][2]), 32'd0);
    check("t1_en_count", 32'(count_en(0, 1, 24)), 32'(12 + PAR));
    check("t1_done", 32'(r_dn[0][15 + PAR]), 32'd1);
    check("t1_ready_back", 32'(r_rd[0][16 + PAR]), 32'd1);
    check("t1_not_ready_done", 32'(r_rd[0][15 + PAR]), 32'd0);
`ifdef PISO_PARITY_EN
    check("t1_parity_bit", 32'(r_sd[0][15]), 32'd0);
    check("t1_parity_en", 32'(r_en[0][15]), 32'd1);
`endif

    // Back-to-back with valid held.
    wait_idle();
    sample_frame(12'hFFF, 12'h001, 2 * la - 1, 1);
    check("t2_first_bits", 32'(bits_of(0, 3, 1)), 32'h0000_0FFF);
    check("t2_ready_gap", 32'(r_rd[0][la]), 32'd1);
    check("t2_second_sync", 32'(r_fs[0][la + 1]), 32'd1);
    check("t2_second_bits", 32'(bits_of(0, la + 3, 1)), 32'h0000_0001);

    // Slow bit rate, no lead-in.
    wait_idle();
    sample_frame(12'h800, 12'h000, 48, 0);
    check("t3_en_c1", 32'(r_en[1][1]), 32'd0);
    check("t3_bit0_c2", 32'({r_en[1][2], r_sd[1][2]}), 32'd3);
    check("t3_bit0_c3", 32'(r_sd[1][3]), 32'd1);
    check("t3_bit0_c4", 32'(r_sd[1][4]), 32'd1);
    check("t3_bit1_c5", 32'(r_sd[1][5]), 32'd0);
    check("t3_en_count", 32'(count_en(1, 1, 48)), 32'(36 + 3 * PAR));
    check("t3_en_last", 32'({r_en[1][37 + 3 * PAR], r_en[1][38 + 3 * PAR]}), 32'd2);
    check("t3_done", 32'(r_dn[1][38 + 3 * PAR]), 32'd1);

    // Reset asserted mid-frame.
    wait_idle();
    @(negedge clk);
    tx_valid = 1'b1;
    tx_data  = 12'hA5C;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      tx_valid = 1'b0;
    end
    #2 reset_b = 1'b0;
    #1;
    check("t4_abort_a", 32'({rdy[0], fs[0], sd[0], en[0], dn[0], bz[0]}), 32'(6'b100000));
    check("t4_abort_b", 32'({rdy[1], fs[1], sd[1], en[1], dn[1], bz[1]}), 32'(6'b100000));
    dn_seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      dn_seen = dn_seen | dn[0] | dn[1];
    end
    reset_b = 1'b1;
    repeat (20) begin
      @(negedge clk);
      dn_seen = dn_seen | dn[0] | dn[1];
    end
    check("t4_no_done", 32'(dn_seen), 32'd0);
    check("t4_ready", 32'(rdy), 32'd3);
    sample_frame(12'h3C5, 12'h000, 20, 0);
    check("t4_new_bits", 32'(bits_of(0, 3, 1)), 32'h0000_03C5);
    check("t4_new_done", 32'(r_dn[0][15 + PAR]), 32'd1);

    // LSB set: parity bit (when present) is 1.
    wait_idle();
    sample_frame(12'h001, 12'h000, 20, 0);
    check("t5_lsb", 32'(r_sd[0][14]), 32'd1);
    check("t5_extra_en", 32'(r_en[0][15]), 32'(PAR));
    check("t5_extra_bit", 32'(r_sd[0][15]), 32'(PAR));
    check("t5_done", 32'(r_dn[0][15 + PAR]), 32'd1);

    // Valid and data wiggling during the frame must not disturb it.
    wait_idle();
    sample_frame(12'h5A3, 12'h000, 20, 2);
    check("t6_bits", 32'(bits_of(0, 3, 1)), 32'h0000_05A3);
    check("t6_sync_once", 32'(r_fs[0][15:2]), 32'd0);
    check("t6_busy_ready", 32'(r_rd[0][15 + PAR:1]), 32'd0);

    // Random traffic with one reset pulse; the per-cycle compare does the checking.
    wait_idle();
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      tx_valid = ($urandom_range(0, 3) != 0);
      tx_data  = DW'($urandom);
      if (c == 1500) #2 reset_b = 1'b0;
      if (c == 1503) reset_b = 1'b1;
    end
    tx_valid = 1'b0;
    wait_idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
